// File: rtl/wl_decoder_seq.sv
// Sequenced wordline decoder: single-row or ascending-sweep pulses with registered one-hot outputs.
// Build option: define WL_DECODER_SEQ_GAP_EN to insert one all-zero GAP cycle between sweep rows.
module wl_decoder_seq #(
    parameter int ADDR_W  = 3,
    parameter int PULSE_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic                 req_sweep,
    input  logic [PULSE_W-1:0]   pulse_len,
    input  logic                 abort,
    output logic [2**ADDR_W-1:0] wl,
    output logic [ADDR_W-1:0]    cur_addr,
    output logic                 busy,
    output logic                 done
);
    localparam int N = 2**ADDR_W;

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, GAP, DONE} state_t;

    state_t             state, state_nxt;
    logic [PULSE_W-1:0] cnt, cnt_nxt;
    logic [PULSE_W-1:0] len_r, len_nxt;
    logic               sweep_r, sweep_nxt;
    logic [N-1:0]       wl_nxt;
    logic [ADDR_W-1:0]  cur_nxt;
    logic               done_nxt, busy_nxt, ready_nxt;
    logic               last_row;
    logic [ADDR_W-1:0]  addr_inc;

    // A zero pulse length is clamped up to a single cycle.
    function automatic logic [PULSE_W-1:0] eff_len(input logic [PULSE_W-1:0] len);
        eff_len = (len == '0) ? PULSE_W'(1) : len;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [ADDR_W-1:0] a);
        onehot    = '0;
        onehot[a] = 1'b1;
    endfunction

    assign last_row = (cur_addr == {ADDR_W{1'b1}});
    assign addr_inc = cur_addr + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wl_nxt    = '0;
        cur_nxt   = cur_addr;
        cnt_nxt   = cnt;
        len_nxt   = len_r;
        sweep_nxt = sweep_r;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_nxt = SETUP;
                    cur_nxt   = req_addr;
                    sweep_nxt = req_sweep;
                    len_nxt   = eff_len(pulse_len);
                end
            end
            SETUP: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = PULSE;
                    wl_nxt    = onehot(cur_addr);
                    cnt_nxt   = len_r - PULSE_W'(1);
                end
            end
            PULSE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt != '0) begin
                    wl_nxt  = onehot(cur_addr);
                    cnt_nxt = cnt - PULSE_W'(1);
                end else if (sweep_r && !last_row) begin
`ifdef WL_DECODER_SEQ_GAP_EN
                    state_nxt = GAP;
                    cur_nxt   = addr_inc;
`else
                    // Row hand-off on a single edge: next row's bit replaces the current one.
                    state_nxt = PULSE;
                    cur_nxt   = addr_inc;
                    wl_nxt    = onehot(addr_inc);
                    cnt_nxt   = len_r - PULSE_W'(1);
`endif
                end else begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = PULSE;
                    wl_nxt    = onehot(cur_addr);
                    cnt_nxt   = len_r - PULSE_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt  = (state_nxt != IDLE);
        ready_nxt = (state_nxt == IDLE);
    end

    // Output and context registers all track the next state so every output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wl        <= '0;
            cur_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            req_ready <= 1'b1;
            cnt       <= '0;
            len_r     <= PULSE_W'(1);
            sweep_r   <= 1'b0;
        end else begin
            wl        <= wl_nxt;
            cur_addr  <= cur_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            req_ready <= ready_nxt;
            cnt       <= cnt_nxt;
            len_r     <= len_nxt;
            sweep_r   <= sweep_nxt;
        end
    end
endmodule
